blocpu_program_loader: RTL and testbench

Synthesizable successor to the simulation-only program runner for `blocpu_core`. It accepts a framed byte stream, packs bytes into instruction words of any width, and writes them sequentially into the core's instruction memory while holding the core in reset. It then releases and starts the core, waits for it to halt, and reports the cycle count, word count, overflow and timeout status. It sits between a host link (UART/SPI byte receiver) and the core's instruction-write and run/reset controls.

---
 rtl/blocpu_program_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_blocpu_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/blocpu_program_loader.sv
// blocpu_program_loader
// ---------------------
// Receives a framed byte stream from a host link, packs it into instruction
// words, writes them into the core's instruction memory while the core is
// held in reset, then releases and runs the core until it halts (or until
// the optional run-phase limit expires) and reports the run statistics.
//
// Frame: N_hi, N_lo (16-bit word count, big-endian), then N words of BPW
// bytes each, big-endian. N == 0 reruns the program already in memory.
//
// Ports
//   in_clock, in_reset            clock (rising edge), async active-high reset
//   in_byte, in_byte_valid        stream byte and its qualifier
//   out_byte_ready                loader accepts a byte this cycle
//   out_instruction[_address]     instruction write data / address
//   out_instruction_write         one-cycle write strobe
//   out_core_reset, out_core_run  core reset request / run request (level)
//   in_core_running               core status, dropped when the core halts
//   out_busy, out_done            frame in progress / last run finished
//   out_timeout, out_overflow     last run timed out / frame exceeded depth
//   out_cycle_count               RUN cycles of the last run (saturating)
//   out_words_loaded              words actually written by the last frame
module blocpu_program_loader #(
    parameter int INSTR_WIDTH    = 12,
    parameter int ADDR_WIDTH     = 16,
    parameter int COUNT_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic [7:0]             in_byte,
    input  logic                   in_byte_valid,
    output logic                   out_byte_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_instruction_address,
    output logic                   out_instruction_write,
    output logic                   out_core_reset,
    output logic                   out_core_run,
    input  logic                   in_core_running,
    output logic                   out_busy,
    output logic                   out_done,
    output logic                   out_timeout,
    output logic                   out_overflow,
    output logic [COUNT_WIDTH-1:0] out_cycle_count,
    output logic [16:0]            out_words_loaded
);

    localparam int BPW = (INSTR_WIDTH + 7) / 8;
    localparam int SHW = BPW * 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_DATA, S_WRITE, S_RELEASE, S_ARM, S_RUN, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [16:0]            wcnt_q, wcnt_d;     // words processed in this frame
    logic [BIW-1:0]         bidx_q, bidx_d;
    logic [SHW-1:0]         shift_q, shift_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic                   ready_q, ready_d;
    logic                   core_reset_q, core_reset_d;
    logic                   run_q, run_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [16:0]            words_q, words_d;

    logic                   take_s;
    logic                   in_range_s;
    logic [15:0]            len_full_s;
    logic [SHW-1:0]         shift_next_s;
    logic                   to_hit_s;

    assign take_s       = in_byte_valid & ready_q;
    // Words whose index is at or beyond the memory depth are consumed but never written.
    assign in_range_s   = ((wcnt_q >> ADDR_WIDTH) == 17'd0);
    assign len_full_s   = {len_q[15:8], in_byte};
    assign shift_next_s = (shift_q << 8) | SHW'(in_byte);
    assign to_hit_s     = (TIMEOUT_CYCLES != 0) &&
                          (cycle_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath computation.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        bidx_d     = bidx_q;
        shift_d    = shift_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        write_d    = 1'b0;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        cycle_d    = cycle_q;
        words_d    = words_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // First byte of a frame: N_hi; flags of the previous frame clear here.
                if (take_s) begin
                    len_d      = {in_byte, 8'h00};
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                    words_d    = 17'd0;
                    state_d    = S_LEN_LO;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (take_s) begin
                    len_d  = len_full_s;
                    wcnt_d = 17'd0;
                    bidx_d = {BIW{1'b0}};
                    if (len_full_s == 16'd0) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (take_s) begin
                    shift_d = shift_next_s;
                    if (bidx_q == BIW'(BPW - 1)) begin
                        // Upper bits of the first byte fall off here.
                        bidx_d  = {BIW{1'b0}};
                        instr_d = shift_next_s[INSTR_WIDTH-1:0];
                        addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                        write_d = in_range_s;
                        state_d = S_WRITE;
                    end else begin
                        bidx_d = bidx_q + BIW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                wcnt_d = wcnt_q + 17'd1;
                if (write_q) begin
                    words_d = words_q + 17'd1;
                end else begin
                    overflow_d = 1'b1;
                end
                if ((wcnt_q + 17'd1) == {1'b0, len_q}) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RELEASE: begin
                cycle_d = {COUNT_WIDTH{1'b0}};
                state_d = S_ARM;
            end
            S_ARM: begin
                if (in_core_running) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_RUN: begin
                // The cycle that observes the halt is counted as a RUN cycle.
                if (cycle_q != {COUNT_WIDTH{1'b1}}) begin
                    cycle_d = cycle_q + COUNT_WIDTH'(1);
                end else begin
                    cycle_d = cycle_q;
                end
                if (!in_core_running) begin
                    state_d = S_DONE;
                end else if (to_hit_s) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs decoded from the next state so they register in step with it.
    always_comb begin
        ready_d      = 1'b0;
        core_reset_d = 1'b1;
        run_d        = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        case (state_d)
            S_IDLE:    begin ready_d = 1'b1; busy_d = 1'b0; end
            S_LEN_LO:  begin ready_d = 1'b1; end
            S_DATA:    begin ready_d = 1'b1; end
            S_WRITE:   begin ready_d = 1'b0; end
            S_RELEASE: begin core_reset_d = 1'b0; end
            S_ARM:     begin core_reset_d = 1'b0; run_d = 1'b1; end
            S_RUN:     begin core_reset_d = 1'b0; run_d = 1'b1; end
            S_DONE:    begin ready_d = 1'b1; busy_d = 1'b0; done_d = 1'b1; end
            default:   begin ready_d = 1'b0; end
        endcase
    end

    // State and output registers.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            wcnt_q       <= 17'd0;
            bidx_q       <= {BIW{1'b0}};
            shift_q      <= {SHW{1'b0}};
            instr_q      <= {INSTR_WIDTH{1'b0}};
            addr_q       <= {ADDR_WIDTH{1'b0}};
            write_q      <= 1'b0;
            ready_q      <= 1'b1;
            core_reset_q <= 1'b1;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            cycle_q      <= {COUNT_WIDTH{1'b0}};
            words_q      <= 17'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            bidx_q       <= bidx_d;
            shift_q      <= shift_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            ready_q      <= ready_d;
            core_reset_q <= core_reset_d;
            run_q        <= run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            cycle_q      <= cycle_d;
            words_q      <= words_d;
        end
    end

    assign out_byte_ready          = ready_q;
    assign out_instruction         = instr_q;
    assign out_instruction_address = addr_q;
    assign out_instruction_write   = write_q;
    assign out_core_reset          = core_reset_q;
    assign out_core_run            = run_q;
    assign out_busy                = busy_q;
    assign out_done                = done_q;
    assign out_timeout             = timeout_q;
    assign out_overflow            = overflow_q;
    assign out_cycle_count         = cycle_q;
    assign out_words_loaded        = words_q;

endmodule

// File: tb/tb_blocpu_program_loader.sv
// Directed bench for blocpu_program_loader. Three instances share the clock,
// reset and byte bus: dut_a (defaults), dut_t (TIMEOUT_CYCLES=100) and
// dut_o (ADDR_WIDTH=2). Each has its own valid and core-running inputs.
module tb_blocpu_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_s;
    logic [2:0]  vld;
    logic [2:0]  crun_in;

    always #5 clk = ~clk;

    // dut_a wires
    logic a_rdy, a_wr, a_creset, a_crun, a_busy, a_done, a_tmo, a_ovf;
    logic [11:0] a_instr; logic [15:0] a_addr; logic [31:0] a_cc; logic [16:0] a_wl;
    // dut_t wires
    logic t_rdy, t_wr, t_creset, t_crun, t_busy, t_done, t_tmo, t_ovf;
    logic [11:0] t_instr; logic [15:0] t_addr; logic [31:0] t_cc; logic [16:0] t_wl;
    // dut_o wires
    logic o_rdy, o_wr, o_creset, o_crun, o_busy, o_done, o_tmo, o_ovf;
    logic [11:0] o_instr; logic [1:0] o_addr; logic [31:0] o_cc; logic [16:0] o_wl;

    blocpu_program_loader dut_a (
        .in_clock(clk), .in_reset(rst), .in_byte(byte_s), .in_byte_valid(vld[0]),
        .out_byte_ready(a_rdy), .out_instruction(a_instr), .out_instruction_address(a_addr),
        .out_instruction_write(a_wr), .out_core_reset(a_creset), .out_core_run(a_crun),
        .in_core_running(crun_in[0]), .out_busy(a_busy), .out_done(a_done),
        .out_timeout(a_tmo), .out_overflow(a_ovf), .out_cycle_count(a_cc),
        .out_words_loaded(a_wl));

    blocpu_program_loader #(.TIMEOUT_CYCLES(100)) dut_t (
        .in_clock(clk), .in_reset(rst), .in_byte(byte_s), .in_byte_valid(vld[1]),
        .out_byte_ready(t_rdy), .out_instruction(t_instr), .out_instruction_address(t_addr),
        .out_instruction_write(t_wr), .out_core_reset(t_creset), .out_core_run(t_crun),
        .in_core_running(crun_in[1]), .out_busy(t_busy), .out_done(t_done),
        .out_timeout(t_tmo), .out_overflow(t_ovf), .out_cycle_count(t_cc),
        .out_words_loaded(t_wl));

    blocpu_program_loader #(.ADDR_WIDTH(2)) dut_o (
        .in_clock(clk), .in_reset(rst), .in_byte(byte_s), .in_byte_valid(vld[2]),
        .out_byte_ready(o_rdy), .out_instruction(o_instr), .out_instruction_address(o_addr),
        .out_instruction_write(o_wr), .out_core_reset(o_creset), .out_core_run(o_crun),
        .in_core_running(crun_in[2]), .out_busy(o_busy), .out_done(o_done),
        .out_timeout(o_tmo), .out_overflow(o_ovf), .out_cycle_count(o_cc),
        .out_words_loaded(o_wl));

    logic [2:0] rdy_v, run_v, done_v;
    assign rdy_v  = {o_rdy, t_rdy, a_rdy};
    assign run_v  = {o_crun, t_crun, a_crun};
    assign done_v = {o_done, t_done, a_done};

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int xfer_cyc = 0;

    // Cycle index, updated on each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Write-strobe and core-control event monitors.
    logic [15:0] wa_addr[$]; logic [11:0] wa_data[$]; int wa_cyc[$];
    logic [1:0]  wo_addr[$]; logic [11:0] wo_data[$];
    int   a_fall_cyc = -1, a_rise_cyc = -1;
    logic a_creset_prev = 1'b1, a_crun_prev = 1'b0;
    always @(negedge clk) begin
        if (a_wr === 1'b1) begin
            wa_addr.push_back(a_addr); wa_data.push_back(a_instr); wa_cyc.push_back(cyc);
        end
        if (o_wr === 1'b1) begin
            wo_addr.push_back(o_addr); wo_data.push_back(o_instr);
        end
        if (a_creset_prev && !a_creset) a_fall_cyc <= cyc;
        if (!a_crun_prev && a_crun) a_rise_cyc <= cyc;
        a_creset_prev <= a_creset;
        a_crun_prev   <= a_crun;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        int g;
        g = 0;
        @(negedge clk);
        byte_s   = b;
        vld[sel] = 1'b1;
        while (rdy_v[sel] !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) check("ready_wait", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        xfer_cyc = cyc;
        vld[sel] = 1'b0;
    endtask

    // kind 0 waits for run, kind 1 for done; returns at a falling edge.
    task automatic wait_sig(input string tag, input int sel, input int kind, input int bound);
        int g;
        g = 0;
        @(negedge clk);
        while (((kind == 0) ? run_v[sel] : done_v[sel]) !== 1'b1 && g < bound) begin
            @(negedge clk);
            g++;
        end
        if (g >= bound) check(tag, 64'd0, 64'd1);
    endtask

    // Core model: starts when run is seen, stays running for n sampled edges.
    task automatic run_core(input int sel, input int n);
        wait_sig("run_wait", sel, 0, 20);
        crun_in[sel] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        crun_in[sel] = 1'b0;
    endtask

    logic [11:0] prog [0:11] = '{12'h800, 12'h940, 12'hB09, 12'hC05, 12'hD01, 12'h681,
                                 12'h313, 12'h405, 12'h30C, 12'hEFF, 12'hFFF, 12'h306};
    logic [15:0] ovw  [0:5]  = '{16'hF123, 16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF, 16'h0111};
    int xa [0:11];
    int base;
    int arm_cyc;

    initial begin
        rst = 1'b1; vld = 3'b000; crun_in = 3'b000; byte_s = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", 64'({a_rdy, a_wr, a_creset, a_crun, a_busy, a_done, a_tmo, a_ovf}),
              64'(8'b1010_0000));
        check("rst_data", 64'({a_instr, a_addr}), 64'd0);
        check("rst_cnt", 64'({a_cc, a_wl}), 64'd0);

        // Full 12-word program into dut_a, then a 37-cycle run.
        send_byte(0, 8'h00);
        check("busy_len", 64'(a_busy), 64'd1);
        send_byte(0, 8'h0C);
        for (int i = 0; i < 12; i++) begin
            send_byte(0, {4'h0, prog[i][11:8]});
            send_byte(0, prog[i][7:0]);
            xa[i] = xfer_cyc;
        end
        run_core(0, 37);
        wait_sig("done_wait_a", 0, 1, 10);
        check("wr_count", 64'(wa_addr.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < wa_addr.size()) begin
                check($sformatf("wr_addr%0d", i), 64'(wa_addr[i]), 64'(i));
                check($sformatf("wr_data%0d", i), 64'(wa_data[i]), 64'(prog[i]));
                check($sformatf("wr_cyc%0d", i), 64'(wa_cyc[i]), 64'(xa[i]));
            end
        end
        check("creset_fall", 64'(a_fall_cyc), 64'(xa[11] + 1));
        check("run_rise", 64'(a_rise_cyc), 64'(xa[11] + 2));
        check("a_done", 64'({a_done, a_creset, a_crun, a_busy, a_tmo, a_ovf}), 64'(6'b110000));
        check("a_cycles", 64'(a_cc), 64'd37);
        check("a_words", 64'(a_wl), 64'd12);

        // Empty frame from DONE: reruns existing program, no writes.
        base = wa_addr.size();
        send_byte(0, 8'h00);
        check("done_clr", 64'({a_done, a_busy}), 64'(2'b01));
        check("wl_clr", 64'(a_wl), 64'd0);
        send_byte(0, 8'h00);
        run_core(0, 5);
        wait_sig("done_wait_b", 0, 1, 10);
        check("n0_nowrite", 64'(wa_addr.size()), 64'(base));
        check("n0_cycles", 64'(a_cc), 64'd5);
        check("n0_done", 64'({a_done, a_creset, a_crun}), 64'(3'b110));

        // Timeout: core never halts.
        send_byte(1, 8'h00); send_byte(1, 8'h01);
        send_byte(1, 8'h0A); send_byte(1, 8'hBC);
        wait_sig("run_wait_t", 1, 0, 20);
        arm_cyc = cyc;
        crun_in[1] = 1'b1;
        wait_sig("done_wait_t", 1, 1, 300);
        check("to_latency", 64'(cyc - arm_cyc), 64'd101);
        check("to_cycles", 64'(t_cc), 64'd100);
        check("to_flags", 64'({t_tmo, t_crun, t_done, t_creset}), 64'(4'b1011));
        crun_in[1] = 1'b0;

        // Overflow: depth 4, six words.
        send_byte(2, 8'h00); send_byte(2, 8'h06);
        for (int i = 0; i < 6; i++) begin
            send_byte(2, ovw[i][15:8]);
            send_byte(2, ovw[i][7:0]);
        end
        repeat (3) @(negedge clk);
        check("ov_count", 64'(wo_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wo_addr.size()) begin
                check($sformatf("ov_addr%0d", i), 64'(wo_addr[i]), 64'(i));
                check($sformatf("ov_data%0d", i), 64'(wo_data[i]), 64'(ovw[i][11:0]));
            end
        end
        check("ov_flag", 64'(o_ovf), 64'd1);
        check("ov_words", 64'(o_wl), 64'd4);
        check("ov_run", 64'({o_crun, o_creset}), 64'(2'b10));

        // Reset in the middle of DATA, then reload from address 0.
        send_byte(0, 8'h00); send_byte(0, 8'h03); send_byte(0, 8'h81);
        check("mid_busy", 64'(a_busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_ctl", 64'({a_rdy, a_wr, a_creset, a_crun, a_busy, a_done, a_tmo, a_ovf}),
              64'(8'b1010_0000));
        check("mr_data", 64'({a_instr, a_addr}), 64'd0);
        check("mr_cnt", 64'({a_cc, a_wl}), 64'd0);
        check("mr_other", 64'({o_ovf, o_wl, t_tmo, t_cc}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        base = wa_addr.size();
        send_byte(0, 8'h00); send_byte(0, 8'h01);
        send_byte(0, 8'h05); send_byte(0, 8'h55);
        repeat (2) @(negedge clk);
        check("rl_count", 64'(wa_addr.size()), 64'(base + 1));
        if (wa_addr.size() > base) begin
            check("rl_addr", 64'(wa_addr[base]), 64'd0);
            check("rl_data", 64'(wa_data[base]), 64'h555);
        end
        check("rl_words", 64'(a_wl), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
